// File: rtl/output_port_scheduler.sv
// Round-robin egress scheduler: streams whole packets from three port buffers onto one byte link.
// Optional CRC checker enabled by defining SCHED_CRC_CHECK_EN.
module output_port_scheduler #(
  parameter int PTR_IN_SZ = 4,
  parameter int UWIDTH    = 8
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 rempty_port_1,
  input  logic                 rempty_port_2,
  input  logic                 rempty_port_3,
  input  logic [UWIDTH-1:0]    rdata_port_1,
  input  logic [UWIDTH-1:0]    rdata_port_2,
  input  logic [UWIDTH-1:0]    rdata_port_3,
  output logic [PTR_IN_SZ-1:0] raddr_port_1,
  output logic [PTR_IN_SZ-1:0] raddr_port_2,
  output logic [PTR_IN_SZ-1:0] raddr_port_3,
  output logic                 rinc_port_1,
  output logic                 rinc_port_2,
  output logic                 rinc_port_3,
  input  logic                 out_ready_i,
  output logic [UWIDTH-1:0]    pdata_o,
  output logic                 packet_valid_o,
  output logic [1:0]           port_sel_o,
  output logic                 busy_o,
  output logic                 crc_err_o,
  output logic [7:0]           err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RELEASE
  } state_t;

  state_t               state;
  logic [1:0]           rr_ptr;
  logic [1:0]           pick;
  logic [2:0]           pend;
  logic [PTR_IN_SZ-1:0] idx;
  logic [3:0]           len;
  logic [UWIDTH-1:0]    rdata;
  logic                 xfer;
  logic                 last;
  logic                 sending;

  assign pend = {~rempty_port_3, ~rempty_port_2, ~rempty_port_1};

  // First pending port at or after rr_ptr, wrapping 3 -> 1.
  always_comb begin
    pick = 2'd0;
    case (rr_ptr)
      2'd2: begin
        if (pend[1])      pick = 2'd2;
        else if (pend[2]) pick = 2'd3;
        else if (pend[0]) pick = 2'd1;
      end
      2'd3: begin
        if (pend[2])      pick = 2'd3;
        else if (pend[0]) pick = 2'd1;
        else if (pend[1]) pick = 2'd2;
      end
      default: begin
        if (pend[0])      pick = 2'd1;
        else if (pend[1]) pick = 2'd2;
        else if (pend[2]) pick = 2'd3;
      end
    endcase
  end

  always_comb begin
    rdata = '0;
    case (port_sel_o)
      2'd1:    rdata = rdata_port_1;
      2'd2:    rdata = rdata_port_2;
      2'd3:    rdata = rdata_port_3;
      default: rdata = '0;
    endcase
  end

  assign sending        = (state == SEND);
  assign xfer           = sending && out_ready_i;
  assign last           = (idx >= PTR_IN_SZ'(3)) &&
                          (idx == PTR_IN_SZ'(len - 4'd1));
  assign packet_valid_o = sending;
  assign busy_o         = (state != IDLE);
  assign pdata_o        = sending ? rdata : '0;

  assign raddr_port_1 = (sending && port_sel_o == 2'd1) ? idx : '0;
  assign raddr_port_2 = (sending && port_sel_o == 2'd2) ? idx : '0;
  assign raddr_port_3 = (sending && port_sel_o == 2'd3) ? idx : '0;

  assign rinc_port_1 = (state == RELEASE) && (port_sel_o == 2'd1);
  assign rinc_port_2 = (state == RELEASE) && (port_sel_o == 2'd2);
  assign rinc_port_3 = (state == RELEASE) && (port_sel_o == 2'd3);

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= 2'd1;
      idx        <= '0;
      len        <= '0;
      port_sel_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick != 2'd0) begin
            port_sel_o <= pick;
            idx        <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            idx <= idx + 1'b1;
            if (idx == PTR_IN_SZ'(2))
              len <= {1'b0, rdata[2:0]} + 4'd4;
            if (last)
              state <= RELEASE;
          end
        end
        RELEASE: begin
          rr_ptr     <= (port_sel_o == 2'd3) ? 2'd1 : port_sel_o + 2'd1;
          port_sel_o <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_CRC_CHECK_EN
  logic [UWIDTH-1:0] crc;
  logic              crc_err;
  logic [7:0]        err_cnt;

  // XOR of every byte but the last; the last byte is the CRC itself.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      crc     <= '0;
      crc_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      crc_err <= 1'b0;
      if (state == IDLE) begin
        crc <= '0;
      end else if (xfer) begin
        if (last) begin
          if (rdata != crc) begin
            crc_err <= 1'b1;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end
        end else begin
          crc <= crc ^ rdata;
        end
      end
    end
  end

  assign crc_err_o = crc_err;
  assign err_cnt_o = err_cnt;
`else
  assign crc_err_o = 1'b0;
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: buffer models, byte scoreboard, per-scenario tasks.
module tb_output_port_scheduler;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b0;
  logic       rempty_port_1, rempty_port_2, rempty_port_3;
  logic [7:0] rdata_port_1, rdata_port_2, rdata_port_3;
  logic [3:0] raddr_port_1, raddr_port_2, raddr_port_3;
  logic       rinc_port_1, rinc_port_2, rinc_port_3;
  logic       out_ready_i = 1'b1;
  logic [7:0] pdata_o;
  logic       packet_valid_o;
  logic [1:0] port_sel_o;
  logic       busy_o;
  logic       crc_err_o;
  logic [7:0] err_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [1:3][0:63];
  logic [5:0] head [1:3] = '{6'd0, 6'd0, 6'd0};
  int         cnt  [1:3] = '{0, 0, 0};
  logic [7:0] exp_q [1:3][$];
  int         rinc_cnt [1:3] = '{0, 0, 0};
  int         crc_pulses = 0;
  int         runs_q [$];
  int         gaps_q [$];
  logic [1:0] grants_q [$];
  int         run = 0;
  int         gap = 0;
  logic       prev_v = 1'b0;
  logic [3:1] rinc_v;

  output_port_scheduler #(.PTR_IN_SZ(4), .UWIDTH(8)) dut (
    .clk1(clk1), .rst(rst),
    .rempty_port_1(rempty_port_1), .rempty_port_2(rempty_port_2),
    .rempty_port_3(rempty_port_3),
    .rdata_port_1(rdata_port_1), .rdata_port_2(rdata_port_2),
    .rdata_port_3(rdata_port_3),
    .raddr_port_1(raddr_port_1), .raddr_port_2(raddr_port_2),
    .raddr_port_3(raddr_port_3),
    .rinc_port_1(rinc_port_1), .rinc_port_2(rinc_port_2),
    .rinc_port_3(rinc_port_3),
    .out_ready_i(out_ready_i), .pdata_o(pdata_o),
    .packet_valid_o(packet_valid_o), .port_sel_o(port_sel_o),
    .busy_o(busy_o), .crc_err_o(crc_err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk1 = ~clk1;

  assign rempty_port_1 = (cnt[1] == 0);
  assign rempty_port_2 = (cnt[2] == 0);
  assign rempty_port_3 = (cnt[3] == 0);
  assign rdata_port_1  = mem[1][head[1] + 6'(raddr_port_1)];
  assign rdata_port_2  = mem[2][head[2] + 6'(raddr_port_2)];
  assign rdata_port_3  = mem[3][head[3] + 6'(raddr_port_3)];
  assign rinc_v        = {rinc_port_3, rinc_port_2, rinc_port_1};

  // Scoreboard and activity log, sampled mid-cycle.
  always @(negedge clk1) begin
    int p;
    int l;
    if (packet_valid_o) begin
      run++;
      if (!prev_v) begin
        grants_q.push_back(port_sel_o);
        gaps_q.push_back(gap);
      end
      gap = 0;
    end else begin
      if (run != 0) runs_q.push_back(run);
      run = 0;
      gap++;
    end
    prev_v = packet_valid_o;
    if (packet_valid_o && out_ready_i) begin
      p = int'(port_sel_o);
      checks++;
      if (p < 1 || exp_q[p].size() == 0) begin
        errors++;
        $display("FAIL byte_unexpected port=%0d data=%h", p, pdata_o);
      end else begin
        if (pdata_o !== exp_q[p][0]) begin
          errors++;
          $display("FAIL byte port=%0d got=%h exp=%h", p, pdata_o, exp_q[p][0]);
        end
        void'(exp_q[p].pop_front());
      end
    end
    for (int n = 1; n <= 3; n++) begin
      if (rinc_v[n]) begin
        rinc_cnt[n]++;
        checks++;
        if (port_sel_o !== 2'(n) || cnt[n] == 0) begin
          errors++;
          $display("FAIL rinc port=%0d sel=%0d cnt=%0d", n, port_sel_o, cnt[n]);
        end else begin
          l = int'(mem[n][head[n] + 6'd2][2:0]) + 4;
          head[n] = head[n] + 6'(l);
          cnt[n]  = cnt[n] - l;
        end
      end
    end
    if (crc_err_o) crc_pulses++;
  end

  task automatic push_pkt(input int p, input logic [7:0] src, input logic [7:0] dst,
                          input logic [7:0] size, input logic [7:0] dbase,
                          input logic fix_crc, input logic [7:0] crc_val);
    logic [7:0] b [$];
    logic [7:0] x;
    b.push_back(src);
    b.push_back(dst);
    b.push_back(size);
    for (int i = 0; i < int'(size[2:0]); i++) b.push_back(dbase + 8'(i));
    x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    b.push_back(fix_crc ? crc_val : x);
    foreach (b[i]) begin
      mem[p][head[p] + 6'(cnt[p] + i)] = b[i];
      exp_q[p].push_back(b[i]);
    end
    cnt[p] = cnt[p] + b.size();
  endtask

  task automatic rebuild_exp();
    for (int p = 1; p <= 3; p++) begin
      exp_q[p].delete();
      for (int i = 0; i < cnt[p]; i++) exp_q[p].push_back(mem[p][head[p] + 6'(i)]);
    end
  endtask

  task automatic clear_log();
    runs_q.delete();
    gaps_q.delete();
    grants_q.delete();
    rinc_cnt = '{0, 0, 0};
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while ((cnt[1] + cnt[2] + cnt[3] != 0 || busy_o) && k < budget) begin
      @(posedge clk1); #1;
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s timeout after %0d cycles", name, k);
    end
  endtask

  task automatic wait_addr1(input logic [3:0] a, input string name);
    int k = 0;
    while (!(packet_valid_o && port_sel_o == 2'd1 && raddr_port_1 == a) && k < 100) begin
      @(posedge clk1); #1;
      k++;
    end
    checks++;
    if (k >= 100) begin
      errors++;
      $display("FAIL %s addr wait timeout", name);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk1);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({packet_valid_o, busy_o, port_sel_o, pdata_o} !== 12'h0) begin
      errors++;
      $display("FAIL reset_ctl got v=%b b=%b s=%0d d=%h exp 0", packet_valid_o, busy_o, port_sel_o, pdata_o);
    end
    checks++;
    if ({raddr_port_1, raddr_port_2, raddr_port_3, rinc_v} !== 15'h0) begin
      errors++;
      $display("FAIL reset_buf got a=%h/%h/%h rinc=%b exp 0", raddr_port_1, raddr_port_2, raddr_port_3, rinc_v);
    end
    checks++;
    if ({crc_err_o, err_cnt_o} !== 9'h0) begin
      errors++;
      $display("FAIL reset_crc got e=%b c=%0d exp 0", crc_err_o, err_cnt_o);
    end
    do_reset();
    repeat (3) @(posedge clk1);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b exp 0", busy_o);
    end
  endtask

  task automatic test_single_port();
    clear_log();
    push_pkt(2, 8'h11, 8'hA0, 8'h03, 8'hD1, 1'b0, 8'h00);
    wait_idle(100, "single");
    checks++;
    if (grants_q.size() != 1 || grants_q[0] !== 2'd2) begin
      errors++;
      $display("FAIL single_grant got n=%0d exp one grant of port 2", grants_q.size());
    end
    checks++;
    if (runs_q.size() != 1 || runs_q[0] != 7) begin
      errors++;
      $display("FAIL single_len got n=%0d exp one run of 7", runs_q.size());
    end
    checks++;
    if (rinc_cnt[1] != 0 || rinc_cnt[2] != 1 || rinc_cnt[3] != 0) begin
      errors++;
      $display("FAIL single_rinc got %0d/%0d/%0d exp 0/1/0", rinc_cnt[1], rinc_cnt[2], rinc_cnt[3]);
    end
    checks++;
    if (exp_q[2].size() != 0) begin
      errors++;
      $display("FAIL single_left got %0d bytes exp 0", exp_q[2].size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_log();
    push_pkt(1, 8'h01, 8'h10, 8'h02, 8'h40, 1'b0, 8'h00);
    push_pkt(2, 8'h02, 8'h20, 8'h01, 8'h50, 1'b0, 8'h00);
    push_pkt(3, 8'h03, 8'h30, 8'h04, 8'h60, 1'b0, 8'h00);
    wait_idle(200, "rr");
    checks++;
    if (grants_q.size() != 3 || grants_q[0] !== 2'd1 ||
        grants_q[1] !== 2'd2 || grants_q[2] !== 2'd3) begin
      errors++;
      $display("FAIL rr_order got n=%0d exp 1,2,3", grants_q.size());
    end
    checks++;
    if (gaps_q.size() != 3 || gaps_q[1] != 2 || gaps_q[2] != 2) begin
      errors++;
      $display("FAIL rr_gap got n=%0d exp gaps of 2", gaps_q.size());
    end
    checks++;
    if (runs_q.size() != 3 || runs_q[0] != 6 || runs_q[1] != 5 || runs_q[2] != 8) begin
      errors++;
      $display("FAIL rr_len got n=%0d exp 6,5,8", runs_q.size());
    end
  endtask

  task automatic test_sizes();
    clear_log();
    push_pkt(3, 8'h33, 8'h44, 8'h00, 8'h00, 1'b0, 8'h00);
    wait_idle(100, "size0");
    push_pkt(1, 8'h55, 8'h66, 8'hFF, 8'h80, 1'b0, 8'h00);
    wait_idle(100, "sizeff");
    checks++;
    if (runs_q.size() != 2 || runs_q[0] != 4 || runs_q[1] != 11) begin
      errors++;
      $display("FAIL sizes got n=%0d exp runs 4,11", runs_q.size());
    end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    clear_log();
    push_pkt(1, 8'h21, 8'h22, 8'h05, 8'hC0, 1'b0, 8'h00);
    wait_addr1(4'd4, "stall");
    held = exp_q[1][0];
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk1); #1;
      checks++;
      if (pdata_o !== held || raddr_port_1 !== 4'd4 || packet_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got d=%h a=%0d v=%b exp d=%h a=4 v=1",
                 i, pdata_o, raddr_port_1, packet_valid_o, held);
      end
    end
    out_ready_i = 1'b1;
    wait_idle(100, "stall");
    checks++;
    if (runs_q.size() != 1 || runs_q[0] != 12 || exp_q[1].size() != 0) begin
      errors++;
      $display("FAIL stall_len got n=%0d left=%0d exp one run of 12", runs_q.size(), exp_q[1].size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_log();
    push_pkt(1, 8'h71, 8'h72, 8'h04, 8'hE0, 1'b0, 8'h00);
    push_pkt(3, 8'h73, 8'h74, 8'h01, 8'hF0, 1'b0, 8'h00);
    wait_addr1(4'd5, "rstmid");
    rst = 1'b0;
    #1;
    checks++;
    if ({packet_valid_o, busy_o, port_sel_o, pdata_o, raddr_port_1, rinc_port_1} !== 17'h0) begin
      errors++;
      $display("FAIL rstmid_zero got v=%b b=%b s=%0d d=%h a=%0d exp 0",
               packet_valid_o, busy_o, port_sel_o, pdata_o, raddr_port_1);
    end
    repeat (2) @(posedge clk1);
    #1;
    checks++;
    if (rinc_cnt[1] != 0 || cnt[1] != 8) begin
      errors++;
      $display("FAIL rstmid_rinc got rinc=%0d cnt=%0d exp 0 and 8", rinc_cnt[1], cnt[1]);
    end
    rebuild_exp();
    runs_q.delete();
    grants_q.delete();
    rst = 1'b1;
    wait_idle(200, "rstmid");
    checks++;
    if (grants_q.size() != 2 || grants_q[0] !== 2'd1 || grants_q[1] !== 2'd3) begin
      errors++;
      $display("FAIL rstmid_order got n=%0d exp 1,3", grants_q.size());
    end
    checks++;
    if (runs_q.size() != 2 || runs_q[0] != 8 || rinc_cnt[1] != 1 || rinc_cnt[3] != 1) begin
      errors++;
      $display("FAIL rstmid_resend got n=%0d rinc=%0d/%0d exp run 8 and one rinc each",
               runs_q.size(), rinc_cnt[1], rinc_cnt[3]);
    end
  endtask

`ifdef SCHED_CRC_CHECK_EN
  task automatic test_crc();
    do_reset();
    crc_pulses = 0;
    push_pkt(1, 8'h01, 8'h02, 8'h01, 8'hAA, 1'b1, 8'hA8);
    wait_idle(100, "crc_good");
    checks++;
    if (crc_pulses != 0 || err_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL crc_good got p=%0d c=%0d exp 0/0", crc_pulses, err_cnt_o);
    end
    push_pkt(1, 8'h01, 8'h02, 8'h01, 8'hAA, 1'b1, 8'h00);
    wait_idle(100, "crc_bad");
    checks++;
    if (crc_pulses != 1 || err_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL crc_bad got p=%0d c=%0d exp 1/1", crc_pulses, err_cnt_o);
    end
    for (int i = 0; i < 300; i++) begin
      push_pkt(2, 8'h01, 8'h02, 8'h01, 8'hAA, 1'b1, 8'h00);
      wait_idle(50, "crc_sat");
    end
    checks++;
    if (crc_pulses != 301 || err_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL crc_sat got p=%0d c=%0d exp 301/255", crc_pulses, err_cnt_o);
    end
  endtask
`else
  task automatic test_crc();
    crc_pulses = 0;
    push_pkt(1, 8'h01, 8'h02, 8'h01, 8'hAA, 1'b1, 8'h00);
    wait_idle(100, "crc_off");
    checks++;
    if (crc_pulses != 0 || err_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL crc_off got p=%0d c=%0d exp 0/0", crc_pulses, err_cnt_o);
    end
  endtask
`endif

  initial begin
    for (int p = 1; p <= 3; p++)
      for (int i = 0; i < 64; i++) mem[p][i] = 8'h00;
    test_reset();
    test_single_port();
    test_round_robin();
    test_sizes();
    test_stall();
    test_reset_mid();
    test_crc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/output_port_scheduler.md
# output_port_scheduler

Round-robin scheduler that shares one outbound byte link among the three per-port packet buffers filled by the router's packet receiver. It detects which buffers hold a complete packet, grants one port at a time, streams that packet out byte by byte under a ready handshake, then releases the buffer slot. It sits between the port buffers' read side and the router's egress link.

## Interface
- PTR_IN_SZ, 4, buffer address width; must be ≥4 because the largest packet is 11 bytes.
- UWIDTH, 8, byte width of buffer data and link data.
- clk1  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rempty_port_1/2/3  in  1 each  low = buffer n holds at least one complete packet at its base.
- rdata_port_1/2/3  in  UWIDTH each  buffer n combinational read data at raddr_port_n.
- raddr_port_1/2/3  out  PTR_IN_SZ each  read address into buffer n.
- rinc_port_1/2/3  out  1 each  one-cycle pulse: packet in buffer n consumed.
- out_ready_i  in  1  egress link accepts a byte this cycle.
- pdata_o  out  UWIDTH  outgoing byte.
- packet_valid_o  out  1  pdata_o valid.
- port_sel_o  out  2  granted port: 1, 2 or 3; 0 when idle.
- busy_o  out  1  high from grant through release.
- crc_err_o  out  1  CRC mismatch pulse (see Configuration).
- err_cnt_o  out  8  saturating CRC error count (see Configuration).

## Operation
- Packet layout in buffer, addresses 0..len-1: SRC, DST, SIZE, DATA×k, CRC; k = SIZE[2:0]; len = k+4 (4..11).
- States: IDLE, SEND, RELEASE.
- IDLE: if any rempty_port_n low, pick first non-empty port in round-robin order starting at rr_ptr; register port_sel_o, clear idx, go SEND. Otherwise stay.
- SEND: packet_valid_o=1; raddr_port_sel = idx; pdata_o = rdata_port_sel (combinational mux). Transfer occurs on an edge with out_ready_i=1; then idx increments. On transfer of idx==2, capture len = rdata[2:0]+4 (4-bit). On transfer of idx==len-1 (idx≥3), go RELEASE.
- RELEASE: rinc_port_sel pulses for one cycle; rr_ptr = granted port+1 (3 wraps to 1); port_sel_o cleared; go IDLE.
- Non-granted raddr_port_n hold 0; all rinc low except in RELEASE.
- Changes on rempty of the granted port during SEND are ignored; rempty of other ports only sampled in IDLE.
- Round-robin: after reset rr_ptr=1, so with all three pending, grant order is 1,2,3,1,...

## Timing
- Reset (async, immediate): state IDLE, rr_ptr=1, idx=0, len=0, raddr all 0, rinc all 0, pdata_o=0, packet_valid_o=0, port_sel_o=0, busy_o=0, crc_err_o=0, err_cnt_o=0. Reset mid-packet abandons it without rinc; the packet is resent in full later.
- Grant latency: rempty low sampled at edge N → packet_valid_o high from edge N+1.
- With out_ready_i held high a packet occupies exactly len cycles of packet_valid_o.
- out_ready_i low stalls: pdata_o, raddr, idx held; no byte lost or repeated.
- Inter-packet gap: packet_valid_o low for exactly 2 cycles (RELEASE, IDLE) between back-to-back packets.
- rinc pulse is one cycle, the cycle after the last byte's transfer edge.

## Configuration
- SCHED_CRC_CHECK_EN defined: running XOR of bytes 0..len-2 of the current packet; when the CRC byte transfers, if it differs from the XOR, crc_err_o pulses high the following cycle (RELEASE) and err_cnt_o increments, saturating at 255. Packet is still sent and released.
- Not defined: no checker logic; crc_err_o and err_cnt_o tied 0.

## Test plan
- Port 2 only, SIZE=8'h03, bytes 11,A0,03,D1,D2,D3,CRC, out_ready_i=1 → 7 consecutive valid bytes in order, port_sel_o=2, rinc_port_2 one pulse, others never.
- All three pending from reset → grants 1,2,3, each packet separated by exactly 2 invalid cycles.
- SIZE=8'h00 → 4-byte packet (SRC,DST,SIZE,CRC); SIZE=8'hFF → 11 bytes (k=7 from low bits).
- out_ready_i low for 3 cycles at idx=4 → pdata_o and raddr stable for those cycles, total packet 3 cycles longer, no duplicates.
- rst low mid-packet at idx=5 → all outputs 0 immediately, no rinc; after release, same packet resent from byte 0 with port 1 priority.
- With SCHED_CRC_CHECK_EN: bytes 01,02,01,AA, CRC 0xA8 → no error; CRC 0x00 → crc_err_o one pulse, err_cnt_o=1; 300 bad packets → err_cnt_o=255.
